// File: rtl/team_08_pixel_writer.sv
// Parallel-bus LCD frame writer: issues the window/RAM-write header, then
// scans every pixel, resolving region flags into an RGB565 color per pixel.
`default_nettype none
`timescale 1ns/1ps

module team_08_pixel_writer #(
  parameter int H_PIX  = 320,
  parameter int V_PIX  = 240,
  parameter int WR_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        r_floor,
  input  logic        r_dino,
  input  logic        r_cactus,
  input  logic        r_cloud,
  input  logic        r_idle,
  input  logic        r_over,
  input  logic        r_win,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [15:0] lcd_data,
  output logic        lcd_wr_n,
  output logic        lcd_dc,
  output logic        lcd_cs_n,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_FETCH  = 3'd2,
    S_WAIT   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [2:0] LOW_LAST = 3'(WR_LOW - 1);
  localparam logic [2:0] LOW_END  = 3'(WR_LOW);
  localparam logic [8:0] X_LAST   = 9'(H_PIX - 1);
  localparam logic [7:0] Y_LAST   = 8'(V_PIX - 1);
  localparam logic [3:0] HDR_LAST = 4'd10;

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] hdr_idx;
  logic [3:0] hdr_sel;
  logic [8:0] hdr_word;
  logic [15:0] color;

  // Header entry is {dc, byte}: column window 0..319, row window 0..239, RAM write.
  function automatic logic [8:0] hdr_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_rom = {1'b0, 8'h2A};
      4'd1:    hdr_rom = {1'b1, 8'h00};
      4'd2:    hdr_rom = {1'b1, 8'h00};
      4'd3:    hdr_rom = {1'b1, 8'h01};
      4'd4:    hdr_rom = {1'b1, 8'h3F};
      4'd5:    hdr_rom = {1'b0, 8'h2B};
      4'd6:    hdr_rom = {1'b1, 8'h00};
      4'd7:    hdr_rom = {1'b1, 8'h00};
      4'd8:    hdr_rom = {1'b1, 8'h00};
      4'd9:    hdr_rom = {1'b1, 8'hEF};
      4'd10:   hdr_rom = {1'b0, 8'h2C};
      default: hdr_rom = {1'b1, 8'h00};
    endcase
  endfunction

  always_comb begin
    hdr_sel  = (state == S_IDLE) ? 4'd0 : hdr_idx + 4'd1;
    hdr_word = hdr_rom(hdr_sel);
    if (r_over)        color = 16'hF800;
    else if (r_win)    color = 16'h07E0;
    else if (r_idle)   color = 16'hFFE0;
    else if (r_dino)   color = 16'h001F;
    else if (r_cactus) color = 16'h03E0;
    else if (r_cloud)  color = 16'hFFFF;
    else if (r_floor)  color = 16'h8410;
    else               color = 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      hdr_idx    <= 4'd0;
      x          <= 9'd0;
      y          <= 8'd0;
      lcd_data   <= 16'h0000;
      lcd_wr_n   <= 1'b1;
      lcd_dc     <= 1'b1;
      lcd_cs_n   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state    <= S_HEADER;
            busy     <= 1'b1;
            lcd_cs_n <= 1'b0;
            hdr_idx  <= 4'd0;
            cnt      <= 3'd0;
            lcd_dc   <= hdr_word[8];
            lcd_data <= {8'h00, hdr_word[7:0]};
            lcd_wr_n <= 1'b0;
          end
        end
        S_HEADER: begin
          // Each write: WR_LOW cycles low, then one high cycle that closes it.
          if (cnt == LOW_END) begin
            if (hdr_idx == HDR_LAST) begin
              state <= S_FETCH;
            end else begin
              hdr_idx  <= hdr_idx + 4'd1;
              lcd_dc   <= hdr_word[8];
              lcd_data <= {8'h00, hdr_word[7:0]};
              lcd_wr_n <= 1'b0;
              cnt      <= 3'd0;
            end
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt == LOW_LAST) lcd_wr_n <= 1'b1;
          end
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          lcd_data <= color;
          lcd_dc   <= 1'b1;
          lcd_wr_n <= 1'b0;
          cnt      <= 3'd0;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          if (cnt == LOW_END) begin
            if (x == X_LAST) begin
              x <= 9'd0;
              if (y == Y_LAST) begin
                y          <= 8'd0;
                state      <= S_DONE;
                frame_done <= 1'b1;
              end else begin
                y     <= y + 8'd1;
                state <= S_FETCH;
              end
            end else begin
              x     <= x + 9'd1;
              state <= S_FETCH;
            end
          end else begin
            cnt <= cnt + 3'd1;
            if (cnt == LOW_LAST) lcd_wr_n <= 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          lcd_cs_n <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_team_08_pixel_writer.sv
// Scoreboard bench for team_08_pixel_writer on a reduced 32x16 frame.
`default_nettype none
`timescale 1ns/1ps

module tb_team_08_pixel_writer;

  localparam int H        = 32;
  localparam int V        = 16;
  localparam int WL       = 2;
  localparam int HDR_N    = 11;
  localparam int PIX_N    = H * V;
  localparam int BUSY_EXP = HDR_N * (WL + 1) + PIX_N * (WL + 3) + 1;
  localparam int BOUND    = BUSY_EXP + 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        r_floor, r_dino, r_cactus, r_cloud, r_idle, r_over, r_win;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [15:0] lcd_data;
  logic        lcd_wr_n, lcd_dc, lcd_cs_n, busy, frame_done;

  always #5 clk = ~clk;

  team_08_pixel_writer #(.H_PIX(H), .V_PIX(V), .WR_LOW(WL)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .r_floor(r_floor), .r_dino(r_dino), .r_cactus(r_cactus), .r_cloud(r_cloud),
    .r_idle(r_idle), .r_over(r_over), .r_win(r_win),
    .x(x), .y(y), .lcd_data(lcd_data), .lcd_wr_n(lcd_wr_n), .lcd_dc(lcd_dc),
    .lcd_cs_n(lcd_cs_n), .busy(busy), .frame_done(frame_done)
  );

  // Region flags per pixel, bit order {over, win, idle, dino, cactus, cloud, floor}.
  logic [6:0] fmem [H][V];
  logic [6:0] flags = 7'h00;
  assign {r_over, r_win, r_idle, r_dino, r_cactus, r_cloud, r_floor} = flags;
  always @(posedge clk)
    flags <= (x < 9'(H) && y < 8'(V)) ? fmem[x[4:0]][y[3:0]] : 7'h7F;

  typedef struct {
    logic        dc;
    logic [15:0] data;
    int          px;
    int          py;
  } exp_t;
  exp_t q[$];
  exp_t e_cur;

  localparam logic [8:0] HDR [HDR_N] = '{
    {1'b0, 8'h2A}, {1'b1, 8'h00}, {1'b1, 8'h00}, {1'b1, 8'h01}, {1'b1, 8'h3F},
    {1'b0, 8'h2B}, {1'b1, 8'h00}, {1'b1, 8'h00}, {1'b1, 8'h00}, {1'b1, 8'hEF},
    {1'b0, 8'h2C}};

  int tests = 0;
  int fails = 0;
  int n_strobe = 0;
  int n_done = 0;
  int n_busy = 0;
  logic prev_wr_n = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_color(input logic [6:0] f);
    if (f[6]) return 16'hF800;
    if (f[5]) return 16'h07E0;
    if (f[4]) return 16'hFFE0;
    if (f[3]) return 16'h001F;
    if (f[2]) return 16'h03E0;
    if (f[1]) return 16'hFFFF;
    if (f[0]) return 16'h8410;
    return 16'h0000;
  endfunction

  // Monitor: every rising edge of lcd_wr_n is a completed bus write.
  always @(negedge clk) begin
    if (rst) begin
      prev_wr_n = 1'b1;
    end else begin
      if (busy) n_busy++;
      if (frame_done) n_done++;
      check("cs_n_vs_busy", 32'(lcd_cs_n), 32'(!busy));
      if (!prev_wr_n && lcd_wr_n) begin
        n_strobe++;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got data 0x%0h with empty queue", lcd_data);
        end else begin
          e_cur = q.pop_front();
          check("strobe_data", 32'(lcd_data), 32'(e_cur.data));
          check("strobe_dc", 32'(lcd_dc), 32'(e_cur.dc));
          check("strobe_x", 32'(x), 32'(e_cur.px));
          check("strobe_y", 32'(y), 32'(e_cur.py));
        end
      end
      prev_wr_n = lcd_wr_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int mode);
    for (int j = 0; j < V; j++)
      for (int i = 0; i < H; i++) begin
        if (mode == 0) fmem[i][j] = (j <= 3) ? 7'h01 : 7'h00;
        else for (int b = 0; b < 7; b++) fmem[i][j][b] = ($urandom_range(0, 3) == 0);
      end
    if (mode == 1) begin
      fmem[0][0] = 7'b1100000;
      fmem[1][0] = 7'b0001001;
      fmem[2][0] = 7'b0000001;
      fmem[3][0] = 7'b0000000;
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int k = 0; k < HDR_N; k++) begin
      e.dc = HDR[k][8]; e.data = {8'h00, HDR[k][7:0]}; e.px = 0; e.py = 0;
      q.push_back(e);
    end
    for (int j = 0; j < V; j++)
      for (int i = 0; i < H; i++) begin
        e.dc = 1'b1; e.data = ref_color(fmem[i][j]); e.px = i; e.py = j;
        q.push_back(e);
      end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_y"}, 32'(y), 32'd0);
    check({tag, "_data"}, 32'(lcd_data), 32'd0);
    check({tag, "_wr_n"}, 32'(lcd_wr_n), 32'd1);
    check({tag, "_dc"}, 32'(lcd_dc), 32'd1);
    check({tag, "_cs_n"}, 32'(lcd_cs_n), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic wait_pixel(input int px, input int py);
    int k = 0;
    while (!(x == 9'(px) && y == 8'(py)) && k < BOUND) begin tick(); k++; end
    if (k >= BOUND) begin
      tests++; fails++;
      $display("FAIL wait_pixel_timeout: pixel (%0d,%0d) never reached", px, py);
    end
  endtask

  task automatic run_frame(input int mode, input bit extra);
    int s0, d0, b0, k;
    fill(mode);
    push_frame();
    s0 = n_strobe; d0 = n_done; b0 = n_busy;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("hdr_entry_cs_n", 32'(lcd_cs_n), 32'd0);
    check("hdr_entry_busy", 32'(busy), 32'd1);
    if (extra) begin
      repeat (4) tick();
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      wait_pixel(5, 5);
      frame_start = 1'b1; tick(); frame_start = 1'b0;
    end
    k = 0;
    while (!frame_done && k < BOUND) begin tick(); k++; end
    if (k >= BOUND) begin
      tests++; fails++;
      $display("FAIL frame_done_timeout: got no pulse, required one within %0d cycles", BOUND);
    end
    repeat (4) tick();
    check("frame_done_count", 32'(n_done - d0), 32'd1);
    check("strobe_count", 32'(n_strobe - s0), 32'(HDR_N + PIX_N));
    check("busy_cycles", 32'(n_busy - b0), 32'(BUSY_EXP));
    check("queue_drained", 32'(q.size()), 32'd0);
    check("idle_after_busy", 32'(busy), 32'd0);
    check("idle_after_xy", 32'({x, y}), 32'd0);
    q.delete();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check_reset_state("reset");
    repeat (5) tick();
    check_reset_state("reset_hold");

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(1, 1'b1);

    // Mid-frame reset, then a fresh frame must restart from the header.
    fill(1);
    push_frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    wait_pixel(10, 5);
    rst = 1'b1;
    tick();
    check_reset_state("midframe_reset");
    q.delete();
    rst = 1'b0;
    repeat (3) tick();
    check_reset_state("post_reset_idle");
    run_frame(1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/team_08_pixel_writer.md
TEAM_08_PIXEL_WRITER -- requirements
Module: team_08_pixel_writer

Interface
REQ-001 SHALL have parameter H_PIX, default 320, horizontal pixels per line.
REQ-002 SHALL have parameter V_PIX, default 240, lines per frame.
REQ-003 SHALL have parameter WR_LOW, default 1, cycles lcd_wr_n is held low per bus write (range 1-7).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset; it is synchronous and active-high.
REQ-006 SHALL have port frame_start, input, 1 bit, one-cycle request to draw one frame.
REQ-007 SHALL have ports r_floor, r_dino, r_cactus, r_cloud, r_idle, r_over, r_win, each input, 1 bit, region-hit flags registered one cycle after x/y.
REQ-008 SHALL have port x, output, 9 bits, current pixel column, driven from a register.
REQ-009 SHALL have port y, output, 8 bits, current pixel row, driven from a register.
REQ-010 SHALL have port lcd_data, output, 16 bits, parallel LCD bus data.
REQ-011 SHALL have ports lcd_wr_n, lcd_dc, lcd_cs_n, each output, 1 bit: write strobe (active low), data/command select (0 = command), chip select (active low).
REQ-012 SHALL have ports busy and frame_done, each output, 1 bit: frame in progress; one-cycle end-of-frame pulse.

Function
REQ-013 SHALL implement the FSM IDLE -> HEADER -> FETCH -> WAIT -> WRITE -> (FETCH | DONE) -> IDLE.
REQ-014 SHALL leave IDLE only when frame_start=1 in IDLE; frame_start in any other state is ignored and is not queued.
REQ-015 HEADER SHALL issue 11 bus writes in this order: cmd 0x2A; data 0x00, 0x00, 0x01, 0x3F; cmd 0x2B; data 0x00, 0x00, 0x00, 0xEF; cmd 0x2C.
REQ-016 Header bytes SHALL be on lcd_data[7:0] with [15:8]=0; lcd_dc=0 for commands, 1 for data.
REQ-017 Every bus write SHALL drive lcd_data/lcd_dc stable, hold lcd_wr_n low WR_LOW cycles, then high 1 cycle (WR_LOW+1 cycles total); data is valid at the rising edge of lcd_wr_n.
REQ-018 lcd_cs_n SHALL be 0 in HEADER, FETCH, WAIT, WRITE and DONE, and 1 in IDLE.
REQ-019 FETCH (1 cycle) SHALL present the current x/y; x/y SHALL stay stable through the end of WRITE.
REQ-020 WAIT (1 cycle) SHALL sample the flags at its closing edge and load lcd_data with the color, lcd_dc=1.
REQ-021 Color priority, highest first: r_over 0xF800; r_win 0x07E0; r_idle 0xFFE0; r_dino 0x001F; r_cactus 0x03E0; r_cloud 0xFFFF; r_floor 0x8410; none 0x0000.
REQ-022 WRITE SHALL strobe one pixel per REQ-017.
REQ-023 Scan order SHALL be x-inner and y-outer, starting at (0,0).
REQ-024 At the end of WRITE: if x<H_PIX-1, x increments; otherwise x goes to 0 and y increments.
REQ-025 After pixel (H_PIX-1, V_PIX-1), the FSM SHALL go to DONE and x/y SHALL go to (0,0).
REQ-026 DONE SHALL last 1 cycle with frame_done=1, then return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Pixel cost SHALL be WR_LOW+3 cycles; header cost SHALL be 11*(WR_LOW+1) cycles.
REQ-029 x/y arithmetic SHALL never exceed 319/239 at default parameters; no wrap-around within a frame.

Reset
REQ-030 rst=1 at a clock edge SHALL, in the next cycle, enter IDLE with x=0, y=0, lcd_data=0, lcd_wr_n=1, lcd_dc=1, lcd_cs_n=1, busy=0, frame_done=0.
REQ-031 rst SHALL take priority over frame_start and over any in-progress write; no partial-frame resume.

Verification
REQ-032 Reset: rst=1 for 2 cycles, then 0 -> all outputs per REQ-030; they hold with frame_start=0.
REQ-033 Header: frame_start pulse -> first 11 lcd_wr_n rising edges carry 0x2A,0x00,0x00,0x01,0x3F,0x2B,0x00,0x00,0x00,0xEF,0x2C with dc pattern 0,1,1,1,1,0,1,1,1,1,0; lcd_cs_n low from the HEADER entry.
REQ-034 Priority: flags over=1,win=1 -> 0xF800; dino=1,floor=1 -> 0x001F; floor only -> 0x8410; none -> 0x0000 at the WRITE strobe edge.
REQ-035 Full frame, WR_LOW=1, flag model = register of (y<=100) as floor -> 76800 pixel writes; busy high 307223 cycles; frame_done pulses exactly once; pixel (0,100) is 0x8410 and (0,101) is 0x0000.
REQ-036 Mid-frame reset: rst at pixel (100,50) -> next cycle per REQ-030; new frame_start restarts with the 0x2A header.
REQ-037 frame_start repeated during HEADER and at pixel (5,5) -> ignored; exactly one frame_done and 76811 write strobes total.
